// File: rtl/sodor_1stage_mem_arbiter.sv
// sodor_1stage_mem_arbiter
// Shares one single-outstanding memory port between instruction fetch and
// load/store traffic of the 1-stage core. Data requests have priority, so the
// executing instruction finishes before the next fetch goes out. The block also
// owns the instruction buffer, the data-miss stall flag and the registered
// interrupt edge.
// Optional feature: define SODOR_MEM_ARB_TIMEOUT_EN to bound wait states with
// an 8-bit counter. A wait that reaches TIMEOUT_CYCLES is aborted and flagged
// on bus_err.
module sodor_1stage_mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              imem_req_valid,
    input  logic [ADDR_W-1:0] imem_req_addr,
    input  logic              inst_consume,
    output logic              imem_resp_valid,
    output logic [DATA_W-1:0] if_inst_buffer,
    input  logic              dmem_req_valid,
    input  logic [ADDR_W-1:0] dmem_req_addr,
    input  logic              dmem_req_wen,
    input  logic [DATA_W-1:0] dmem_req_wdata,
    output logic              dmem_resp_valid,
    output logic [DATA_W-1:0] dmem_resp_data,
    output logic              reg_dmiss,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_wen,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    input  logic              interrupt,
    output logic              reg_interrupt_edge,
    output logic              bus_err
);

    typedef enum logic [1:0] {IDLE, I_WAIT, D_WAIT} state_t;

    state_t state;
    state_t state_next;
    logic   accept;
    logic   timeout;
    logic   ibuf_valid;
    logic   int_q;

    assign imem_resp_valid = ibuf_valid;
    assign accept          = mem_req_valid & mem_req_ready;

`ifdef SODOR_MEM_ARB_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       bus_err_q;

    // A wait is aborted only when no response arrives in the limit cycle.
    assign timeout = (state != IDLE) && !mem_resp_valid
                     && (wait_cnt == 8'(TIMEOUT_CYCLES));
    assign bus_err = bus_err_q;

    // Wait counter: held at zero while idle, counts every cycle spent waiting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt  <= 8'd0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= timeout;
            if (state == IDLE) begin
                wait_cnt <= 8'd0;
            end else begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

    // Request mux: only IDLE may issue, data wins over fetch.
    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_addr  = imem_req_addr;
        mem_req_wen   = 1'b0;
        mem_req_wdata = '0;
        if (state == IDLE) begin
            mem_req_valid = dmem_req_valid | (imem_req_valid & ~ibuf_valid);
        end
        if (dmem_req_valid) begin
            mem_req_addr  = dmem_req_addr;
            mem_req_wen   = dmem_req_wen;
            mem_req_wdata = dmem_req_wdata;
        end
    end

    // Next state: one outstanding request; a response or abort returns to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = dmem_req_valid ? D_WAIT : I_WAIT;
                end
            end
            I_WAIT, D_WAIT: begin
                if (mem_resp_valid || timeout) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; reset abandons any outstanding request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Response capture, instruction buffer, stall flag and interrupt edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ibuf_valid         <= 1'b0;
            if_inst_buffer     <= '0;
            dmem_resp_valid    <= 1'b0;
            dmem_resp_data     <= '0;
            reg_dmiss          <= 1'b0;
            int_q              <= 1'b0;
            reg_interrupt_edge <= 1'b0;
        end else begin
            // A fill in the same cycle as a consume leaves the buffer valid.
            if (state == I_WAIT && mem_resp_valid) begin
                if_inst_buffer <= mem_resp_data;
                ibuf_valid     <= 1'b1;
            end else if (inst_consume) begin
                ibuf_valid <= 1'b0;
            end

            dmem_resp_valid <= (state == D_WAIT) && (mem_resp_valid || timeout);
            if (state == D_WAIT && mem_resp_valid) begin
                dmem_resp_data <= mem_resp_data;
            end else if (state == D_WAIT && timeout) begin
                dmem_resp_data <= '0;
            end

            reg_dmiss <= (state_next == D_WAIT)
                         || (state == IDLE && dmem_req_valid && !accept);

            int_q              <= interrupt;
            reg_interrupt_edge <= interrupt & ~int_q;
        end
    end

endmodule

// File: tb/tb_sodor_1stage_mem_arbiter.sv
// Testbench for sodor_1stage_mem_arbiter (default build, timeout macro undefined).
// Directed scenarios followed by randomized traffic, all checked against a
// transaction-level reference model of the arbiter.
module tb_sodor_1stage_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        inst_consume;
    logic        imem_resp_valid;
    logic [31:0] if_inst_buffer;
    logic        dmem_req_valid;
    logic [31:0] dmem_req_addr;
    logic        dmem_req_wen;
    logic [31:0] dmem_req_wdata;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_data;
    logic        reg_dmiss;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        interrupt;
    logic        reg_interrupt_edge;
    logic        bus_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: which kind of request is outstanding (0 none, 1 fetch,
    // 2 data) plus the values the core should see on its registered outputs.
    int          pend;
    logic        m_ibuf_v;
    logic [31:0] m_ibuf;
    logic        m_dresp_v;
    logic [31:0] m_dresp;
    logic        m_dmiss;
    logic        m_edge;
    logic        m_irq_prev;

    sodor_1stage_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(255)) dut (
        .clock(clock), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .inst_consume(inst_consume), .imem_resp_valid(imem_resp_valid),
        .if_inst_buffer(if_inst_buffer),
        .dmem_req_valid(dmem_req_valid), .dmem_req_addr(dmem_req_addr),
        .dmem_req_wen(dmem_req_wen), .dmem_req_wdata(dmem_req_wdata),
        .dmem_resp_valid(dmem_resp_valid), .dmem_resp_data(dmem_resp_data),
        .reg_dmiss(reg_dmiss),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .interrupt(interrupt), .reg_interrupt_edge(reg_interrupt_edge),
        .bus_err(bus_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        pend       = 0;
        m_ibuf_v   = 1'b0;
        m_ibuf     = '0;
        m_dresp_v  = 1'b0;
        m_dresp    = '0;
        m_dmiss    = 1'b0;
        m_edge     = 1'b0;
        m_irq_prev = 1'b0;
    endtask

    task automatic check_regs();
        check("ibuf_valid", imem_resp_valid, m_ibuf_v);
        check("if_inst_buffer", if_inst_buffer, m_ibuf);
        check("dmem_resp_valid", dmem_resp_valid, m_dresp_v);
        check("dmem_resp_data", dmem_resp_data, m_dresp);
        check("reg_dmiss", reg_dmiss, m_dmiss);
        check("irq_edge", reg_interrupt_edge, m_edge);
        check("bus_err", bus_err, 1'b0);
    endtask

    // One clock cycle: called just after a falling edge with inputs driven.
    task automatic cycle();
        logic exp_v;
        logic acc;
        logic resp;
        logic was_idle;
        #1;
        exp_v = (pend == 0) && (dmem_req_valid || (imem_req_valid && !m_ibuf_v));
        check("mem_req_valid", mem_req_valid, exp_v);
        if (exp_v) begin
            check("mem_req_addr", mem_req_addr, dmem_req_valid ? dmem_req_addr : imem_req_addr);
            check("mem_req_wen", mem_req_wen, dmem_req_valid & dmem_req_wen);
            check("mem_req_wdata", mem_req_wdata, dmem_req_valid ? dmem_req_wdata : 32'h0);
        end
        @(posedge clock);
        acc      = exp_v && mem_req_ready;
        resp     = mem_resp_valid && (pend != 0);
        was_idle = (pend == 0);
        m_dresp_v = resp && (pend == 2);
        if (m_dresp_v) m_dresp = mem_resp_data;
        if (resp && pend == 1) begin
            m_ibuf_v = 1'b1;
            m_ibuf   = mem_resp_data;
        end else if (inst_consume) begin
            m_ibuf_v = 1'b0;
        end
        if (resp) pend = 0;
        else if (was_idle && acc) pend = dmem_req_valid ? 2 : 1;
        m_dmiss    = (pend == 2) || (was_idle && dmem_req_valid && !acc);
        m_edge     = interrupt && !m_irq_prev;
        m_irq_prev = interrupt;
        #1;
        check_regs();
        @(negedge clock);
    endtask

    // Asynchronous reset pulse, started just after a falling edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_regs();
        check("rst_mem_req_valid", mem_req_valid,
              dmem_req_valid | (imem_req_valid & ~m_ibuf_v));
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        reset = 1'b1;
        imem_req_valid = 0; imem_req_addr = 0; inst_consume = 0;
        dmem_req_valid = 0; dmem_req_addr = 0; dmem_req_wen = 0; dmem_req_wdata = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0; interrupt = 0;
        model_reset();
        repeat (2) @(negedge clock);
        check_regs();
        check("reset_mem_req_valid", mem_req_valid, 1'b0);
        reset = 1'b0;

        // Fetch at 0x200, response two cycles after acceptance.
        imem_req_valid = 1; imem_req_addr = 32'h200; mem_req_ready = 1;
        cycle();
        mem_req_ready = 0;
        cycle();
        mem_resp_valid = 1; mem_resp_data = 32'h0000_0013;
        cycle();
        mem_resp_valid = 0;
        check("t1_inst_valid", imem_resp_valid, 1'b1);
        check("t1_inst", if_inst_buffer, 32'h13);

        // Buffer full, fetch held: nothing issued until the consume.
        mem_req_ready = 1;
        cycle();
        cycle();
        check("t3_no_fetch", mem_req_valid, 1'b0);
        mem_req_ready = 0; inst_consume = 1;
        cycle();
        inst_consume = 0; imem_req_addr = 32'h204;
        #1;
        check("t3_fetch_after_consume", mem_req_valid, 1'b1);

        // Load and fetch together: data goes first, stall until response.
        dmem_req_valid = 1; dmem_req_addr = 32'h1000; dmem_req_wen = 0; mem_req_ready = 1;
        #1;
        check("t2_addr_data_first", mem_req_addr, 32'h1000);
        cycle();
        check("t2_dmiss_set", reg_dmiss, 1'b1);
        mem_req_ready = 0;
        cycle();
        cycle();
        check("t2_dmiss_held", reg_dmiss, 1'b1);
        mem_resp_valid = 1; mem_resp_data = 32'hCAFE_F00D;
        cycle();
        mem_resp_valid = 0; dmem_req_valid = 0;
        check("t2_dresp_valid", dmem_resp_valid, 1'b1);
        check("t2_dresp_data", dmem_resp_data, 32'hCAFE_F00D);
        check("t2_dmiss_drop", reg_dmiss, 1'b0);
        #1;
        check("t2_fetch_follows", mem_req_valid, 1'b1);
        check("t2_fetch_addr", mem_req_addr, 32'h204);
        mem_req_ready = 1;
        cycle();
        mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 32'h0010_0093;
        cycle();
        mem_resp_valid = 0; imem_req_valid = 0; inst_consume = 1;
        cycle();
        inst_consume = 0;

        // Reset during a store wait; the late response must be dropped.
        dmem_req_valid = 1; dmem_req_addr = 32'h2000; dmem_req_wen = 1;
        dmem_req_wdata = 32'h55; mem_req_ready = 1;
        cycle();
        mem_req_ready = 0;
        cycle();
        dmem_req_valid = 0;
        do_reset();
        mem_resp_valid = 1; mem_resp_data = 32'hDEAD_BEEF;
        cycle();
        check("t4_stale_ignored", dmem_resp_valid, 1'b0);
        mem_resp_valid = 0;
        cycle();
        check("t4_still_idle", dmem_resp_valid, 1'b0);

        // Interrupt rise held several cycles gives a single edge pulse.
        interrupt = 1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (reg_interrupt_edge) pulses++;
        end
        check("t5_edge_pulses", pulses, 1);
        interrupt = 0;
        cycle();

        // Randomized traffic, including stray responses and mid-flight resets.
        for (int i = 0; i < 3000; i++) begin
            imem_req_valid = ($urandom_range(0, 3) != 0);
            imem_req_addr  = $urandom & 32'hFFFF_FFFC;
            inst_consume   = ($urandom_range(0, 2) == 0);
            dmem_req_valid = ($urandom_range(0, 2) == 0);
            dmem_req_addr  = $urandom;
            dmem_req_wen   = $urandom_range(0, 1);
            dmem_req_wdata = $urandom;
            mem_req_ready  = $urandom_range(0, 1);
            mem_resp_valid = ($urandom_range(0, 4) < 2);
            mem_resp_data  = $urandom;
            if ($urandom_range(0, 9) == 0) interrupt = ~interrupt;
            if ($urandom_range(0, 199) == 0) do_reset();
            else cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
